// File: rtl/mux4to1_16b_sched.sv
// Round-robin scheduler for the shared 16-bit 4:1 adiabatic mux.
// Holds the select for HOLD_CYCLES before capturing mux_out.
module mux4to1_16b_sched #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [15:0] mux_out,
  output logic        in0,
  output logic        in1,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [15:0] result_q, result_d;
  logic        rv_q, rv_d;

  logic        win_vld;
  logic [1:0]  win_idx;

  // Scan from the slot after the last winner, wrapping back to it last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      if (!win_vld && req[ptr_q + 2'(i)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    ack_d    = 4'b0000;
    busy_d   = busy_q;
    result_d = result_q;
    rv_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_SETUP;
          sel_d   = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          busy_d  = 1'b1;
          ptr_d   = win_idx;
        end
      end
      S_SETUP: begin
        cnt_d   = HOLD_INIT;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          result_d = mux_out;
          ack_d    = gnt_q;
          rv_d     = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      ptr_q    <= 2'd3;
      sel_q    <= 2'd0;
      gnt_q    <= 4'b0000;
      ack_q    <= 4'b0000;
      busy_q   <= 1'b0;
      result_q <= 16'h0000;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign in0          = sel_q[0];
  assign in1          = sel_q[1];
  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule
